// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
package sipo_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Bit assembler: shift register plus bit counter with start-of-frame clear.
// word/word_done are combinational and describe the word completing at the coming edge.
module sipo_shreg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted = {shreg_q[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign shifted = {sin, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // The completed word includes the bit being sampled at this edge.
    assign word = shifted;

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        if (sync) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (sin_en) begin
            shreg_d = shifted;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles words and offers them on a
// one-entry valid/ready slot, flagging words dropped while the slot is full.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             ovr_sticky
);

    slot_state_t      state_q;
    logic [WIDTH-1:0] dout_q;
    logic             overrun_q;
    logic             ovr_sticky_q;

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             load_d;
    logic             drop_d;

    sipo_shreg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .sin      (sin),
        .sin_en   (sin_en),
        .sync     (sync),
        .word     (word),
        .word_done(word_done)
    );

    // A full slot being consumed this cycle can take the new word without a bubble.
    always_comb begin
        load_d = word_done && ((state_q == S_EMPTY) || out_ready);
        drop_d = word_done && (state_q == S_FULL) && !out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            dout_q       <= '0;
            overrun_q    <= 1'b0;
            ovr_sticky_q <= 1'b0;
        end else begin
            overrun_q <= drop_d;
            if (drop_d) begin
                ovr_sticky_q <= 1'b1;
            end
            if (load_d) begin
                dout_q <= word;
            end
            case (state_q)
                S_EMPTY: if (load_d) state_q <= S_FULL;
                S_FULL:  if (out_ready && !load_d) state_q <= S_EMPTY;
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign dout       = dout_q;
    assign out_valid  = (state_q == S_FULL);
    assign overrun    = overrun_q;
    assign ovr_sticky = ovr_sticky_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: MSB-first and LSB-first instances share stimulus;
// a bit-list reference model predicts words and per-cycle flags.
module tb_sipo_rx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst, sin, sin_en, sync, out_ready;
    logic [WIDTH-1:0] dout_m, dout_l;
    logic             valid_m, valid_l, ovr_m, ovr_l, sticky_m, sticky_l;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
        .dout(dout_m), .out_valid(valid_m), .out_ready(out_ready),
        .overrun(ovr_m), .ovr_sticky(sticky_m)
    );

    sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
        .dout(dout_l), .out_valid(valid_l), .out_ready(out_ready),
        .overrun(ovr_l), .ovr_sticky(sticky_l)
    );

    typedef struct {
        logic valid;
        logic ovr;
        logic sticky;
        logic chk_zero;
    } flag_t;

    typedef struct {
        logic [WIDTH-1:0] msb;
        logic [WIDTH-1:0] lsb;
    } word_t;

    flag_t flag_q[$];
    word_t word_q[$];

    int checks = 0;
    int passes = 0;

    // Reference model state: bits of the word in progress, slot occupancy, sticky flag.
    logic bits[$];
    logic m_full   = 1'b0;
    logic m_sticky = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic step(input logic r, input logic s, input logic en, input logic sy, input logic rdy);
        flag_t f;
        word_t w;
        logic  loaded;
        rst = r; sin = s; sin_en = en; sync = sy; out_ready = rdy;
        f.ovr = 1'b0;
        f.chk_zero = 1'b0;
        if (r) begin
            bits.delete();
            m_full = 1'b0;
            m_sticky = 1'b0;
            f.chk_zero = 1'b1;
        end else begin
            loaded = 1'b0;
            if (sy) begin
                bits.delete();
            end else if (en) begin
                bits.push_back(s);
                if (bits.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w.msb[WIDTH-1-i] = bits[i];
                        w.lsb[i] = bits[i];
                    end
                    bits.delete();
                    if (!m_full || rdy) begin
                        word_q.push_back(w);
                        m_full = 1'b1;
                        loaded = 1'b1;
                    end else begin
                        f.ovr = 1'b1;
                        m_sticky = 1'b1;
                    end
                end
            end
            if (m_full && rdy && !loaded) m_full = 1'b0;
        end
        f.valid = m_full;
        f.sticky = m_sticky;
        @(posedge clk);
        flag_q.push_back(f);
        #1;
    endtask

    task automatic send(input logic [15:0] b, input int n, input logic rdy);
        for (int i = n - 1; i >= 0; i--) step(1'b0, b[i], 1'b1, 1'b0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy);
    endtask

    // Monitor: per-cycle flag checks, and a word check each time a new word is presented.
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;

    always @(negedge clk) begin
        flag_t f;
        word_t w;
        if (flag_q.size() > 0) begin
            f = flag_q.pop_front();
            check("out_valid_msb", WIDTH'(valid_m), WIDTH'(f.valid));
            check("out_valid_lsb", WIDTH'(valid_l), WIDTH'(f.valid));
            check("overrun", WIDTH'({ovr_l, ovr_m}), WIDTH'({f.ovr, f.ovr}));
            check("ovr_sticky", WIDTH'({sticky_l, sticky_m}), WIDTH'({f.sticky, f.sticky}));
            if (f.chk_zero) begin
                check("reset_dout_msb", dout_m, '0);
                check("reset_dout_lsb", dout_l, '0);
            end
            if (valid_m === 1'b1 && (!prev_valid || prev_hs)) begin
                if (word_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got %b none expected at %0t", dout_m, $time);
                end else begin
                    w = word_q.pop_front();
                    check("dout_msb_first", dout_m, w.msb);
                    check("dout_lsb_first", dout_l, w.lsb);
                    $display("word msb=%b (exp %b) lsb=%b (exp %b) at %0t", dout_m, w.msb, dout_l, w.lsb, $time);
                end
            end
            prev_valid = valid_m;
            prev_hs    = valid_m & out_ready;
        end
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; sync = 1'b0; out_ready = 1'b1;
        // Reset with random serial activity
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        idle(2, 1'b1);
        // Single words, both bit orders observed
        send(16'b1001, 4, 1'b1); idle(3, 1'b1);
        send(16'b1100, 4, 1'b1); idle(3, 1'b1);
        // Back-to-back
        send(16'b1001_1100, 8, 1'b1); idle(3, 1'b1);
        // Gaps inside a word
        send(16'b11, 2, 1'b1); idle(3, 1'b1); send(16'b00, 2, 1'b1); idle(3, 1'b1);
        // Backpressure: second word dropped, then release
        send(16'b1001_1100, 8, 1'b0); idle(2, 1'b0); idle(3, 1'b1);
        // Abort with sync mid-word
        send(16'b11, 2, 1'b1); step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        send(16'b0110, 4, 1'b1); idle(3, 1'b1);
        // Abort with reset mid-word (also clears sticky)
        send(16'b11, 2, 1'b1); step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        send(16'b0110, 4, 1'b1); idle(3, 1'b1);
        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 9) < 6));
        end
        idle(6, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (word_q.size() != 0 || flag_q.size() != 0) begin
            $display("FAIL drain: got %0d words %0d flags pending, required 0 0", word_q.size(), flag_q.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
